// File: rtl/pattern_sequencer.sv
// Purpose: juggling siteswap sequencer. On each beat it throws the ball landing now, or issues a new ball,
//          and records where that ball will land in an 8-slot circular landing table.
// Latency: outputs are registered and appear 1 cycle after the new_beat strobe.
// Backpressure: none. new_beat is a strobe that is never stalled. Beats in IDLE and ERROR are dropped.
//
// Ports:
//   clk_in, rst_n_in            clock and async active-low reset
//   new_beat                    one-cycle beat strobe
//   pattern_in/pattern_length   throw heights (entry 0 first) and used entries (1..7)
//   num_balls_in                ball count
//   pattern_valid_in            level; high = play requested with these inputs
//   throw_valid_out, throw_height_out, ball_id_out, hand_out   throw result (hand 0 right, 1 left)
//   beat_out                    pulse per processed beat
//   error_out, error_code_out   sticky error flag and type (1 EMPTY, 2 COLLISION, 3 DROP)
//   loop_count_out              completed pattern periods (only built with PATTERN_LOOP_COUNT_EN)
//
// Macro PATTERN_LOOP_COUNT_EN enables the saturating loop counter. Without it, loop_count_out is tied to 0.

module pattern_sequencer (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            new_beat,
   input  logic [6:0][2:0] pattern_in,
   input  logic [2:0]      pattern_length,
   input  logic [2:0]      num_balls_in,
   input  logic            pattern_valid_in,
   output logic            throw_valid_out,
   output logic [2:0]      throw_height_out,
   output logic [2:0]      ball_id_out,
   output logic            hand_out,
   output logic            beat_out,
   output logic            error_out,
   output logic [1:0]      error_code_out,
   output logic [15:0]     loop_count_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERROR} state_t;

   localparam logic [1:0] ERR_EMPTY     = 2'd1;
   localparam logic [1:0] ERR_COLLISION = 2'd2;
   localparam logic [1:0] ERR_DROP      = 2'd3;

   state_t          state_q;
   logic [6:0][2:0] pat_q;
   logic [2:0]      len_q;
   logic [2:0]      nballs_q;
   logic [7:0]      tbl_vld_q;
   logic [7:0][2:0] tbl_id_q;
   logic [2:0]      idx_q;
   logic [2:0]      slot_q;
   logic [2:0]      issued_q;
   logic            hand_q;

   logic [2:0]      cur_h;
   logic [2:0]      land_slot;
   logic            last_idx;
   logic            start_go;
   logic            beat_go;
   logic            err_hit;
   logic [1:0]      err_code;
   logic            throw_ok;
   logic            throw_new;
   logic [2:0]      throw_id;

   assign cur_h     = pat_q[idx_q];
   assign land_slot = slot_q + cur_h;          // wraps mod 8
   assign last_idx  = (idx_q == len_q - 3'd1);
   assign start_go  = (state_q == ST_IDLE) && pattern_valid_in && (pattern_length != 3'd0);
   // Dropping pattern_valid_in wins over a coincident beat.
   assign beat_go   = (state_q == ST_RUN) && pattern_valid_in && new_beat;

   // Beat decision. A collision at the landing slot overrides an otherwise good throw.
   always_comb begin
      err_hit   = 1'b0;
      err_code  = 2'd0;
      throw_ok  = 1'b0;
      throw_new = 1'b0;
      throw_id  = tbl_id_q[slot_q];
      if (cur_h != 3'd0) begin
         if (tbl_vld_q[land_slot]) begin
            err_hit  = 1'b1;
            err_code = ERR_COLLISION;
         end else if (tbl_vld_q[slot_q]) begin
            throw_ok = 1'b1;
         end else if (issued_q < nballs_q) begin
            throw_ok  = 1'b1;
            throw_new = 1'b1;
            throw_id  = issued_q;
         end else begin
            err_hit  = 1'b1;
            err_code = ERR_EMPTY;
         end
      end else if (tbl_vld_q[slot_q]) begin
         err_hit  = 1'b1;
         err_code = ERR_DROP;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q          <= ST_IDLE;
         pat_q            <= '0;
         len_q            <= '0;
         nballs_q         <= '0;
         tbl_vld_q        <= '0;
         tbl_id_q         <= '0;
         idx_q            <= '0;
         slot_q           <= '0;
         issued_q         <= '0;
         hand_q           <= 1'b0;
         throw_valid_out  <= 1'b0;
         throw_height_out <= '0;
         ball_id_out      <= '0;
         hand_out         <= 1'b0;
         beat_out         <= 1'b0;
         error_out        <= 1'b0;
         error_code_out   <= '0;
      end else begin
         throw_valid_out <= 1'b0;
         beat_out        <= 1'b0;
         if (state_q != ST_IDLE && !pattern_valid_in) begin
            state_q        <= ST_IDLE;
            tbl_vld_q      <= '0;
            error_out      <= 1'b0;
            error_code_out <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // A beat on the start edge is ignored; play begins on the next strobe.
                  if (start_go) begin
                     state_q   <= ST_RUN;
                     pat_q     <= pattern_in;
                     len_q     <= pattern_length;
                     nballs_q  <= num_balls_in;
                     tbl_vld_q <= '0;
                     idx_q     <= '0;
                     slot_q    <= '0;
                     issued_q  <= '0;
                     hand_q    <= 1'b0;
                  end
               end
               ST_RUN: begin
                  if (beat_go) begin
                     if (err_hit) begin
                        // An erroring beat is not processed: no throw, no advance, no beat_out.
                        state_q        <= ST_ERROR;
                        error_out      <= 1'b1;
                        error_code_out <= err_code;
                     end else begin
                        beat_out         <= 1'b1;
                        hand_out         <= hand_q;
                        throw_valid_out  <= throw_ok;
                        throw_height_out <= throw_ok ? cur_h : 3'd0;
                        ball_id_out      <= throw_ok ? throw_id : 3'd0;
                        if (throw_ok) begin
                           // land_slot never equals slot_q because cur_h is 1..7.
                           tbl_vld_q[slot_q]    <= 1'b0;
                           tbl_vld_q[land_slot] <= 1'b1;
                           tbl_id_q[land_slot]  <= throw_id;
                        end
                        if (throw_new) issued_q <= issued_q + 3'd1;
                        slot_q <= slot_q + 3'd1;
                        hand_q <= ~hand_q;
                        idx_q  <= last_idx ? 3'd0 : idx_q + 3'd1;
                     end
                  end
               end
               default: ;  // ST_ERROR holds until pattern_valid_in drops
            endcase
         end
      end
   end

`ifdef PATTERN_LOOP_COUNT_EN
   logic [15:0] loop_cnt_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         loop_cnt_q <= '0;
      end else if (start_go) begin
         loop_cnt_q <= '0;
      end else if (beat_go && !err_hit && last_idx && loop_cnt_q != 16'hFFFF) begin
         loop_cnt_q <= loop_cnt_q + 16'd1;
      end
   end

   assign loop_count_out = loop_cnt_q;
`else
   assign loop_count_out = 16'd0;
`endif

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have port clk_in, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port new_beat, input, 1, one-cycle beat strobe.
REQ-004 SHALL have port pattern_in, input, [6:0][2:0], siteswap throw heights, entry 0 thrown first.
REQ-005 SHALL have port pattern_length, input, 3, the number of used entries (1..7).
REQ-006 SHALL have port num_balls_in, input, 3, the ball count for the pattern.
REQ-007 SHALL have port pattern_valid_in, input, 1, a level; high means the pattern inputs are valid and play is requested.
REQ-008 SHALL have port throw_valid_out, output, 1, a one-cycle pulse when a ball is thrown.
REQ-009 SHALL have port throw_height_out, output, 3, the height of the current throw.
REQ-010 SHALL have port ball_id_out, output, 3, the identity of the ball thrown.
REQ-011 SHALL have port hand_out, output, 1, the throwing hand: 0 right, 1 left.
REQ-012 SHALL have port beat_out, output, 1, a one-cycle pulse for every beat processed in RUN.
REQ-013 SHALL have port error_out, output, 1, a sticky error flag.
REQ-014 SHALL have port error_code_out, output, 2, the error type: 0 none, 1 EMPTY, 2 COLLISION, 3 DROP.
REQ-015 SHALL have port loop_count_out, output, 16, the number of completed pattern periods.

Function
REQ-016 SHALL implement states IDLE, RUN, ERROR.
REQ-017 IDLE->RUN SHALL occur on the first cycle with pattern_valid_in=1 and pattern_length!=0. On that edge the block latches pattern_in, pattern_length and num_balls_in, clears the landing table, and sets index=0, beat slot=0, balls_issued=0, hand=0.
REQ-018 Latched values SHALL NOT change while in RUN or ERROR; input changes there are ignored.
REQ-019 From RUN or ERROR, the state SHALL go to IDLE in the cycle pattern_valid_in=0 is seen, clearing the table and error_out/error_code_out.
REQ-020 SHALL keep an 8-entry circular landing table: valid bit plus 3-bit ball id per entry, indexed by a 3-bit beat slot s.
REQ-021 On new_beat in RUN, with h = latched pattern[index], the block SHALL act as follows:
  - h>0 and table[s] valid: throw that ball.
  - h>0 and table[s] empty and balls_issued<num_balls: throw ball id balls_issued, then balls_issued+1.
  - h>0, table[s] empty, all balls issued: error EMPTY.
  - h>0 and table[(s+h) mod 8] valid: error COLLISION; this takes priority over a successful throw.
  - h=0 and table[s] valid: error DROP.
  - h=0 and table[s] empty: no throw.
REQ-022 A successful throw SHALL clear table[s] and write the ball into table[(s+h) mod 8]. All 3-bit arithmetic wraps mod 8.
REQ-023 Every processed beat SHALL advance the state as follows:
  - s increments (wraps 7->0).
  - hand toggles.
  - index increments, wrapping to 0 at pattern_length.
  - loop_count_out increments on each wrap, saturating at 16'hFFFF.
REQ-024 Outputs SHALL be registered, with latency exactly 1 cycle after new_beat:
  - beat_out and throw_valid_out are one-cycle pulses.
  - throw_height_out, ball_id_out and hand_out hold until the next beat.
  - hand_out shows the hand of the beat just processed.
REQ-025 On any error, the block SHALL set error_out=1 and error_code_out, make no throw, enter ERROR, and ignore new_beat there (no beat_out).
REQ-026 new_beat in IDLE SHALL be ignored. new_beat on the same edge as the IDLE->RUN transition SHALL be ignored; the first beat is the next strobe.
REQ-027 If pattern_valid_in falls on the same cycle as new_beat, leaving RUN SHALL win and no throw is emitted.

Reset
REQ-028 While rst_n_in=0, the block SHALL asynchronously force:
  - state to IDLE.
  - all outputs to 0.
  - the table to all invalid.
  - index, s, balls_issued and hand to 0.
REQ-029 Reset mid-RUN SHALL abandon play; after release the block waits in IDLE for pattern_valid_in.

Configuration
REQ-030 With macro PATTERN_LOOP_COUNT_EN defined, the block SHALL implement the loop counter per REQ-023. Without it, no counter is built and loop_count_out SHALL be constant 0.

Verification
REQ-031 Pattern {3}, len 1, balls 3, 7 beats -> ball ids 0,1,2,0,1,2,0; heights all 3; hands 0,1,0,1,0,1,0; no error.
REQ-032 Pattern {5,3,1}, len 3, balls 3, 6 beats -> ids 0,1,2,2,1,0; loop_count_out=2 (macro defined).
REQ-033 Pattern {3,2,1}, len 3, balls 2 -> beat 0 throws id 0; beat 1 raises COLLISION (code 2), with no throw_valid_out and no further beat_out.
REQ-034 Pattern {3}, len 1, balls 2 -> beat 2 raises EMPTY (code 1). Dropping pattern_valid_in then returns to IDLE with error_out=0.
REQ-035 Pattern {3,0}, len 2, balls 1, with a reset pulse after beat 1 -> all outputs 0 at once; a new pattern_valid_in restarts from ball 0, hand 0.
